// File: rtl/ram_loader.sv
// Synchronous RAM with a streaming loader that fills addresses 0..DEPTH-1 in order,
// plus a ROM-compatible registered read port. Define RAM_LOADER_FWD_EN for write-first collisions.
module ram_loader #(
  parameter int WIDTH  = 32,
  parameter int AWIDTH = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  output logic              in_ready,
  output logic              done,
  output logic [AWIDTH:0]   count,
  input  logic [AWIDTH-1:0] addr,
  output logic [WIDTH-1:0]  y
);
  localparam int DEPTH = 2 ** AWIDTH;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH:0]   count_q, count_d;
  logic [WIDTH-1:0]  y_q;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              hs;

  assign in_ready = (state_q == S_LOAD);
  assign done     = (state_q == S_DONE);
  assign count    = count_q;
  assign y        = y_q;
  assign hs       = in_valid & in_ready;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_LOAD;
          wr_ptr_d = '0;
          count_d  = '0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          count_d  = count_q + 1'b1;
          if (wr_ptr_q == {AWIDTH{1'b1}}) begin
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Memory contents survive reset; only the handshake gated by reset writes.
  always_ff @(posedge clock) begin
    if (!reset && hs) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      y_q <= '0;
    end else begin
`ifdef RAM_LOADER_FWD_EN
      if (hs && (addr == wr_ptr_q)) begin
        y_q <= in_data;
      end else begin
        y_q <= mem[addr];
      end
`else
      y_q <= mem[addr];
`endif
    end
  end
endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: a vector table, directed passes and random traffic,
// all checked against a pass/count level reference model.
module tb_ram_loader;
  logic        clock = 1'b0;
  logic        reset, start, in_valid;
  logic [31:0] in_data;
  logic        in_ready, done;
  logic [5:0]  count;
  logic [4:0]  addr;
  logic [31:0] y;

  int tests = 0;
  int fails = 0;

  // Reference model: a loading flag, a done flag, words accepted this pass, and the memory image.
  bit          m_load = 0;
  bit          m_done = 0;
  int          m_cnt  = 0;
  logic [31:0] m_mem [32];
  bit          m_wr  [32];

  typedef struct {
    logic        st;
    logic        v;
    logic [31:0] d;
    logic [5:0]  cnt;
    logic        dn;
    logic        rdy;
  } vec_t;
  vec_t tbl [10];

  ram_loader dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .done    (done),
    .count   (count),
    .addr    (addr),
    .y       (y)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, advance the model, then check all outputs just after the edge.
  task automatic cyc(input logic r, input logic s, input logic v,
                     input logic [31:0] d, input logic [4:0] a);
    bit          hs;
    logic [31:0] ye;
    bit          yk;
    reset = r; start = s; in_valid = v; in_data = d; addr = a;
    hs = !r && m_load && v;
    if (r) begin
      ye = '0; yk = 1;
    end else if (hs && a == m_cnt[4:0]) begin
`ifdef RAM_LOADER_FWD_EN
      ye = d; yk = 1;
`else
      ye = m_mem[a]; yk = m_wr[a];
`endif
    end else begin
      ye = m_mem[a]; yk = m_wr[a];
    end
    if (r) begin
      m_load = 0; m_done = 0; m_cnt = 0;
    end else if (m_load) begin
      if (hs) begin
        m_mem[m_cnt[4:0]] = d;
        m_wr[m_cnt[4:0]]  = 1;
        m_cnt++;
        if (m_cnt == 32) begin
          m_load = 0; m_done = 1;
        end
      end
    end else if (s) begin
      m_load = 1; m_done = 0; m_cnt = 0;
    end
    @(posedge clock);
    #1;
    chk("in_ready", 64'(in_ready), 64'(m_load));
    chk("done", 64'(done), 64'(m_done));
    chk("count", 64'(count), 64'(m_cnt));
    if (yk) chk("y", 64'(y), 64'(ye));
    $display("[TB] t=%0t rst=%0b st=%0b v=%0b d=%h a=%0d -> rdy=%0b done=%0b cnt=%0d y=%h",
             $time, r, s, v, d, a, in_ready, done, count, y);
  endtask

  initial begin
    int n_ready;
    for (int i = 0; i < 32; i++) begin
      m_mem[i] = '0; m_wr[i] = 0;
    end
    reset = 1; start = 0; in_valid = 0; in_data = '0; addr = '0;

    for (int i = 0; i < 5; i++)
      tbl[i] = '{st: 1'b0, v: 1'b1, d: 32'hFFFF_0000 + i, cnt: 6'd0, dn: 1'b0, rdy: 1'b0};
    tbl[5] = '{st: 1'b1, v: 1'b1, d: 32'hFFFF_0005, cnt: 6'd0, dn: 1'b0, rdy: 1'b1};
    tbl[6] = '{st: 1'b0, v: 1'b1, d: 32'h7000_0000, cnt: 6'd1, dn: 1'b0, rdy: 1'b1};
    tbl[7] = '{st: 1'b0, v: 1'b0, d: 32'hFFFF_0007, cnt: 6'd1, dn: 1'b0, rdy: 1'b1};
    tbl[8] = '{st: 1'b1, v: 1'b1, d: 32'h7000_0001, cnt: 6'd2, dn: 1'b0, rdy: 1'b1};
    tbl[9] = '{st: 1'b0, v: 1'b1, d: 32'h7000_0002, cnt: 6'd3, dn: 1'b0, rdy: 1'b1};

    // Reset for three cycles with in_valid high.
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 32'h1234_0000 + i, 5'(i));

    // Idle cycles, start, partial load with a gap and an ignored start.
    foreach (tbl[i]) begin
      cyc(0, tbl[i].st, tbl[i].v, tbl[i].d, 5'd0);
      chk("tbl_count", 64'(count), 64'(tbl[i].cnt));
      chk("tbl_done", 64'(done), 64'(tbl[i].dn));
      chk("tbl_ready", 64'(in_ready), 64'(tbl[i].rdy));
    end
    cyc(1, 0, 0, '0, 5'd0);
    for (int a = 0; a < 3; a++) begin
      cyc(0, 0, 0, '0, 5'(a));
      chk("tbl_readback", 64'(y), 64'(32'h7000_0000 + a));
    end

    // Back-to-back pass.
    n_ready = 0;
    cyc(0, 1, 0, '0, 5'd0);
    n_ready += int'(in_ready);
    for (int i = 0; i < 32; i++) begin
      cyc(0, 0, 1, 32'hA000_0000 + i, 5'd0);
      n_ready += int'(in_ready);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 1, 32'hBAD0_0000, 5'd0);
      n_ready += int'(in_ready);
    end
    chk("ready_cycles", 64'(n_ready), 64'd32);
    chk("full_count", 64'(count), 64'd32);
    for (int a = 0; a < 32; a++) begin
      cyc(0, 0, 0, '0, 5'(a));
      chk("sweep_a", 64'(y), 64'(32'hA000_0000 + a));
    end

    // Pass with in_valid toggling every other cycle.
    cyc(0, 1, 0, '0, 5'd0);
    for (int i = 0; i < 64; i++) begin
      if (i % 2 == 0) cyc(0, 0, 1, 32'hA000_0000 + i / 2, 5'd0);
      else            cyc(0, 0, 0, $urandom, 5'd0);
    end
    chk("toggle_count", 64'(count), 64'd32);
    chk("toggle_done", 64'(done), 64'd1);
    for (int a = 0; a < 32; a++) begin
      cyc(0, 0, 0, '0, 5'(a));
      chk("sweep_toggle", 64'(y), 64'(32'hA000_0000 + a));
    end

    // Restart from DONE with a new pattern.
    cyc(0, 1, 0, '0, 5'd0);
    chk("restart_done_low", 64'(done), 64'd0);
    for (int i = 0; i < 32; i++) cyc(0, 0, 1, 32'h5555_0000 + i, 5'd0);
    for (int a = 0; a < 32; a++) begin
      cyc(0, 0, 0, '0, 5'(a));
      chk("sweep_5555", 64'(y), 64'(32'h5555_0000 + a));
    end

    // Reset after 10 words; word 7 is seeded for the collision below.
    cyc(0, 1, 0, '0, 5'd0);
    for (int i = 0; i < 10; i++)
      cyc(0, 0, 1, (i == 7) ? 32'h1111_1111 : 32'hC000_0000 + i, 5'd0);
    cyc(1, 0, 1, 32'hBAD0_0001, 5'd0);
    chk("midreset_count", 64'(count), 64'd0);
    for (int a = 0; a < 12; a++) begin
      cyc(0, 0, 0, '0, 5'(a));
      if (a == 7)      chk("midreset_rd", 64'(y), 64'(32'h1111_1111));
      else if (a < 10) chk("midreset_rd", 64'(y), 64'(32'hC000_0000 + a));
      else             chk("midreset_rd", 64'(y), 64'(32'h5555_0000 + a));
    end

    // New pass resumes at address 0, then a read/write collision at address 7.
    cyc(0, 1, 0, '0, 5'd0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 32'hE000_0000 + i, 5'd0);
    chk("pre_collide_count", 64'(count), 64'd7);
    cyc(0, 0, 1, 32'hDEAD_BEEF, 5'd7);
`ifdef RAM_LOADER_FWD_EN
    chk("collide_y", 64'(y), 64'(32'hDEAD_BEEF));
`else
    chk("collide_y", 64'(y), 64'(32'h1111_1111));
`endif
    cyc(0, 0, 0, '0, 5'd7);
    chk("collide_after", 64'(y), 64'(32'hDEAD_BEEF));
    cyc(0, 0, 0, '0, 5'd0);
    chk("resume_addr0", 64'(y), 64'(32'hE000_0000));
    for (int i = 8; i < 32; i++) cyc(0, 0, 1, 32'hE000_0000 + i, 5'(i));

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom % 100) == 0, ($urandom % 12) == 0, 1'($urandom),
          $urandom, 5'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
